// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order-retire reorder buffer between rename/dispatch and the physical
// register free list. Up to DISPATCH instructions are inserted per cycle
// (all-or-nothing), CMPL ports mark entries complete (optionally with an
// exception), and up to RETIRE completed entries leave per cycle in program
// order, handing back their old physical registers.
//
// An excepting entry reaching the oldest position empties the buffer and
// raises a one-cycle exception report. A mispredict rollback truncates the
// buffer so that i_flush_tag becomes the youngest surviving entry.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_ins_bundle       DISPATCH slot-packed instruction bundles
//   i_ins_old_p        DISPATCH slot-packed old physical registers
//   i_ins_count        number of slots requested this cycle (0..DISPATCH)
//   o_ins_accept       comb: the requested group is inserted at this edge
//   o_ins_tag          comb: entry index assigned to slot 0
//   i_cmpl_tag/exc/en  per-port completion tag, exception flag and valid
//   i_flush_en/tag     rollback request, youngest surviving entry
//   o_free             comb: number of unoccupied entries
//   o_ret_count/ret_p  registered retire count and old pregs (unused slots 0)
//   o_exc_valid/tag/bundle  registered one-cycle exception report
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int LEN       = 16,
  parameter int BWIDTH    = 57,
  parameter int DISPATCH  = 4,
  parameter int RETIRE    = 4,
  parameter int CMPL      = 6,
  parameter int PREG_BITS = 6
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [DISPATCH*BWIDTH-1:0]      i_ins_bundle,
  input  logic [DISPATCH*PREG_BITS-1:0]   i_ins_old_p,
  input  logic [$clog2(DISPATCH+1)-1:0]   i_ins_count,
  output logic                            o_ins_accept,
  output logic [$clog2(LEN)-1:0]          o_ins_tag,
  input  logic [CMPL*$clog2(LEN)-1:0]     i_cmpl_tag,
  input  logic [CMPL-1:0]                 i_cmpl_exc,
  input  logic [CMPL-1:0]                 i_cmpl_en,
  input  logic                            i_flush_en,
  input  logic [$clog2(LEN)-1:0]          i_flush_tag,
  output logic [$clog2(LEN):0]            o_free,
  output logic [$clog2(RETIRE+1)-1:0]     o_ret_count,
  output logic [RETIRE*PREG_BITS-1:0]     o_ret_p,
  output logic                            o_exc_valid,
  output logic [$clog2(LEN)-1:0]          o_exc_tag,
  output logic [BWIDTH-1:0]               o_exc_bundle
);

  localparam int LBITS = $clog2(LEN);
  localparam int PW    = LBITS + 1;              // pointer width incl. wrap bit
  localparam int ICW   = $clog2(DISPATCH + 1);
  localparam int RCW   = $clog2(RETIRE + 1);

  // Architectural state
  logic [BWIDTH-1:0]         bundle_q [LEN];
  logic [BWIDTH-1:0]         bundle_d [LEN];
  logic [PREG_BITS-1:0]      old_p_q  [LEN];
  logic [PREG_BITS-1:0]      old_p_d  [LEN];
  logic [LEN-1:0]            rdy_q, rdy_d, exc_q, exc_d;
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;

  // Registered outputs
  logic [RCW-1:0]            ret_count_q, ret_count_d;
  logic [RETIRE*PREG_BITS-1:0] ret_p_q, ret_p_d;
  logic                      exc_valid_q, exc_valid_d;
  logic [LBITS-1:0]          exc_tag_q, exc_tag_d;
  logic [BWIDTH-1:0]         exc_bundle_q, exc_bundle_d;

  // Combinational helpers
  logic [PW-1:0]             count;
  logic [LBITS-1:0]          tail_idx, head_idx, flush_dist;
  logic                      exc_at_tail, flush_cycle;
  logic [RCW-1:0]            ret_n;
  logic                      walk;
  logic [LBITS-1:0]          win_idx, cmpl_idx, ins_idx, ret_idx;
  logic [LEN-1:0]            cmpl_hit, cmpl_exc_or;

  assign count       = head_q - tail_q;
  assign tail_idx    = tail_q[LBITS-1:0];
  assign head_idx    = head_q[LBITS-1:0];
  assign o_free      = PW'(LEN) - count;
  assign o_ins_tag   = head_idx;

  // Only an occupied oldest entry can raise the exception; stale rdy/exc bits
  // of freed entries are ignored through the count test.
  assign exc_at_tail = (count != '0) && rdy_q[tail_idx] && exc_q[tail_idx];
  assign flush_cycle = exc_at_tail || i_flush_en;

  assign o_ins_accept = (i_ins_count != '0) && (PW'(i_ins_count) <= o_free)
                        && !flush_cycle;

  // Distance from the oldest entry to the rollback target, modulo LEN.
  assign flush_dist = i_flush_tag - tail_idx;

  // Retire window: count the unbroken run of ready, non-excepting entries
  // starting at the oldest one.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no
    // latch is inferred.
    ret_n   = '0;
    walk    = 1'b1;
    win_idx = '0;
    for (int k = 0; k < RETIRE; k++) begin
      win_idx = tail_idx + LBITS'(k);
      if (walk && (PW'(k) < count) && rdy_q[win_idx] && !exc_q[win_idx]) begin
        ret_n = ret_n + RCW'(1);
      end else begin
        walk = 1'b0;
      end
    end
  end

  // Completion decode; ports naming the same entry OR their exception flags.
  always_comb begin
    cmpl_hit    = '0;
    cmpl_exc_or = '0;
    cmpl_idx    = '0;
    for (int p = 0; p < CMPL; p++) begin
      if (i_cmpl_en[p]) begin
        cmpl_idx              = i_cmpl_tag[p*LBITS +: LBITS];
        cmpl_hit[cmpl_idx]    = 1'b1;
        cmpl_exc_or[cmpl_idx] = cmpl_exc_or[cmpl_idx] | i_cmpl_exc[p];
      end
    end
  end

  // Next-state logic
  always_comb begin
    bundle_d     = bundle_q;
    old_p_d      = old_p_q;
    rdy_d        = rdy_q;
    exc_d        = exc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ret_count_d  = '0;
    ret_p_d      = '0;
    exc_valid_d  = 1'b0;
    exc_tag_d    = exc_tag_q;
    exc_bundle_d = exc_bundle_q;
    ins_idx      = '0;
    ret_idx      = '0;

    if (exc_at_tail) begin
      // Precise exception: report the oldest entry, drop everything, free
      // nothing, ignore this cycle's completions.
      exc_valid_d  = 1'b1;
      exc_tag_d    = tail_idx;
      exc_bundle_d = bundle_q[tail_idx];
      head_d       = tail_q;
    end else begin
      rdy_d = rdy_q | cmpl_hit;
      exc_d = (exc_q & ~cmpl_hit) | cmpl_exc_or;

      tail_d      = tail_q + PW'(ret_n);
      ret_count_d = ret_n;
      for (int k = 0; k < RETIRE; k++) begin
        if (RCW'(k) < ret_n) begin
          ret_idx = tail_idx + LBITS'(k);
          ret_p_d[k*PREG_BITS +: PREG_BITS] = old_p_q[ret_idx];
        end
      end

      if (i_flush_en) begin
        head_d = tail_q + {1'b0, flush_dist} + PW'(1);
      end else if (o_ins_accept) begin
        // Allocation is applied after completions so it wins on a clash.
        for (int k = 0; k < DISPATCH; k++) begin
          if (ICW'(k) < i_ins_count) begin
            ins_idx           = head_idx + LBITS'(k);
            bundle_d[ins_idx] = i_ins_bundle[k*BWIDTH +: BWIDTH];
            old_p_d[ins_idx]  = i_ins_old_p[k*PREG_BITS +: PREG_BITS];
            rdy_d[ins_idx]    = 1'b0;
            exc_d[ins_idx]    = 1'b0;
          end
        end
        head_d = head_q + PW'(i_ins_count);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      rdy_q        <= '0;
      exc_q        <= '0;
      ret_count_q  <= '0;
      ret_p_q      <= '0;
      exc_valid_q  <= 1'b0;
      exc_tag_q    <= '0;
      exc_bundle_q <= '0;
      // NOTE: the entry storage is cleared on reset as well, because the
      // exception report exposes stored bundles and a defined value is wanted.
      for (int i = 0; i < LEN; i++) begin
        bundle_q[i] <= '0;
        old_p_q[i]  <= '0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      rdy_q        <= rdy_d;
      exc_q        <= exc_d;
      ret_count_q  <= ret_count_d;
      ret_p_q      <= ret_p_d;
      exc_valid_q  <= exc_valid_d;
      exc_tag_q    <= exc_tag_d;
      exc_bundle_q <= exc_bundle_d;
      bundle_q     <= bundle_d;
      old_p_q      <= old_p_d;
    end
  end

  assign o_ret_count  = ret_count_q;
  assign o_ret_p      = ret_p_q;
  assign o_exc_valid  = exc_valid_q;
  assign o_exc_tag    = exc_tag_q;
  assign o_exc_bundle = exc_bundle_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed bench for reorder_buffer (LEN=16). A queue-based program-order
// model predicts every output each cycle; literal expectations pin the key
// scenarios independently of that model.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int LEN       = 16;
  localparam int BWIDTH    = 57;
  localparam int DISPATCH  = 4;
  localparam int RETIRE    = 4;
  localparam int CMPL      = 6;
  localparam int PG        = 6;
  localparam int LBITS     = $clog2(LEN);
  localparam int ICW       = $clog2(DISPATCH + 1);
  localparam int RCW       = $clog2(RETIRE + 1);
  localparam logic [BWIDTH-1:0] BASE = 57'h1_5A5A_0000_0000;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [DISPATCH*BWIDTH-1:0]  ins_bundle;
  logic [DISPATCH*PG-1:0]      ins_old_p;
  logic [ICW-1:0]              ins_count;
  logic                        ins_accept;
  logic [LBITS-1:0]            ins_tag;
  logic [CMPL*LBITS-1:0]       cmpl_tag;
  logic [CMPL-1:0]             cmpl_exc;
  logic [CMPL-1:0]             cmpl_en;
  logic                        flush_en;
  logic [LBITS-1:0]            flush_tag;
  logic [LBITS:0]              free;
  logic [RCW-1:0]              ret_count;
  logic [RETIRE*PG-1:0]        ret_p;
  logic                        exc_valid;
  logic [LBITS-1:0]            exc_tag;
  logic [BWIDTH-1:0]           exc_bundle;

  reorder_buffer #(
    .LEN(LEN), .BWIDTH(BWIDTH), .DISPATCH(DISPATCH), .RETIRE(RETIRE),
    .CMPL(CMPL), .PREG_BITS(PG)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ins_bundle (ins_bundle),
    .i_ins_old_p  (ins_old_p),
    .i_ins_count  (ins_count),
    .o_ins_accept (ins_accept),
    .o_ins_tag    (ins_tag),
    .i_cmpl_tag   (cmpl_tag),
    .i_cmpl_exc   (cmpl_exc),
    .i_cmpl_en    (cmpl_en),
    .i_flush_en   (flush_en),
    .i_flush_tag  (flush_tag),
    .o_free       (free),
    .o_ret_count  (ret_count),
    .o_ret_p      (ret_p),
    .o_exc_valid  (exc_valid),
    .o_exc_tag    (exc_tag),
    .o_exc_bundle (exc_bundle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  // Program-order model: tags oldest first plus per-tag payload/status.
  int                q_tags[$];
  logic [BWIDTH-1:0] m_bundle [LEN];
  logic [PG-1:0]     m_old    [LEN];
  bit                m_rdy    [LEN];
  bit                m_exc    [LEN];
  int                m_tail = 0;

  int                e_ret_count = 0;
  logic [RETIRE*PG-1:0] e_ret_p = '0;
  bit                e_exc_valid = 1'b0;
  int                e_exc_tag = 0;
  logic [BWIDTH-1:0] e_exc_bundle = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst        = 1'b0;
    ins_bundle = '0;
    ins_old_p  = '0;
    ins_count  = '0;
    cmpl_tag   = '0;
    cmpl_exc   = '0;
    cmpl_en    = '0;
    flush_en   = 1'b0;
    flush_tag  = '0;
  endtask

  task automatic disp(input int n);
    for (int k = 0; k < n; k++) begin
      ins_bundle[k*BWIDTH +: BWIDTH] = BASE + BWIDTH'(seq);
      ins_old_p[k*PG +: PG]          = PG'(seq % 64);
      seq++;
    end
    ins_count = ICW'(n);
  endtask

  task automatic cmpl(input int p, input int tag, input bit e);
    cmpl_en[p]                   = 1'b1;
    cmpl_tag[p*LBITS +: LBITS]   = LBITS'(tag);
    cmpl_exc[p]                  = e;
  endtask

  // Complete up to n of the oldest entries that are not yet ready.
  task automatic cmpl_oldest(input int n);
    int p = 0;
    foreach (q_tags[i]) begin
      if (p < n && !m_rdy[q_tags[i]]) begin
        cmpl(p, q_tags[i], 1'b0);
        p++;
      end
    end
  endtask

  // One clock: check combinational outputs, advance the model at the edge,
  // then check the registered outputs. Entered and left at a falling edge.
  task automatic cycle();
    int cnt, r, pos, t, tail0;
    bit exc_now, acc;
    bit hit [LEN];
    bit exo [LEN];
    #1;
    cnt     = q_tags.size();
    tail0   = m_tail;
    exc_now = (cnt > 0) && m_rdy[q_tags[0]] && m_exc[q_tags[0]];
    acc     = (ins_count != 0) && (int'(ins_count) <= LEN - cnt) && !exc_now && !flush_en;
    if (!rst) begin
      check("free", free, 64'(LEN - cnt));
      check("ins_accept", ins_accept, 64'(acc));
      check("ins_tag", ins_tag, 64'((tail0 + cnt) % LEN));
    end
    @(posedge clk);
    if (rst) begin
      q_tags.delete();
      m_tail = 0;
      for (int i = 0; i < LEN; i++) begin
        m_bundle[i] = '0; m_old[i] = '0; m_rdy[i] = 1'b0; m_exc[i] = 1'b0;
      end
      e_ret_count = 0; e_ret_p = '0;
      e_exc_valid = 1'b0; e_exc_tag = 0; e_exc_bundle = '0;
    end else if (exc_now) begin
      e_exc_valid  = 1'b1;
      e_exc_tag    = q_tags[0];
      e_exc_bundle = m_bundle[q_tags[0]];
      q_tags.delete();
      e_ret_count  = 0;
      e_ret_p      = '0;
    end else begin
      e_exc_valid = 1'b0;
      r = 0;
      while (r < RETIRE && r < cnt && m_rdy[q_tags[r]] && !m_exc[q_tags[r]]) r++;
      e_ret_p = '0;
      for (int k = 0; k < r; k++) e_ret_p[k*PG +: PG] = m_old[q_tags[k]];
      e_ret_count = r;
      if (flush_en) begin
        pos = (int'(flush_tag) - tail0 + LEN) % LEN;
        while (q_tags.size() > pos + 1) void'(q_tags.pop_back());
      end
      for (int k = 0; k < r; k++) void'(q_tags.pop_front());
      m_tail = (tail0 + r) % LEN;
      for (int i = 0; i < LEN; i++) begin hit[i] = 1'b0; exo[i] = 1'b0; end
      for (int p = 0; p < CMPL; p++) begin
        if (cmpl_en[p]) begin
          t = int'(cmpl_tag[p*LBITS +: LBITS]);
          hit[t] = 1'b1;
          exo[t] = exo[t] | cmpl_exc[p];
        end
      end
      for (int i = 0; i < LEN; i++) begin
        if (hit[i]) begin m_rdy[i] = 1'b1; m_exc[i] = exo[i]; end
      end
      if (acc) begin
        for (int k = 0; k < int'(ins_count); k++) begin
          t = (tail0 + cnt + k) % LEN;
          q_tags.push_back(t);
          m_bundle[t] = ins_bundle[k*BWIDTH +: BWIDTH];
          m_old[t]    = ins_old_p[k*PG +: PG];
          m_rdy[t]    = 1'b0;
          m_exc[t]    = 1'b0;
        end
      end
    end
    #1;
    check("ret_count", ret_count, 64'(e_ret_count));
    check("ret_p", ret_p, 64'(e_ret_p));
    check("exc_valid", exc_valid, 64'(e_exc_valid));
    check("exc_tag", exc_tag, 64'(e_exc_tag));
    check("exc_bundle", exc_bundle, 64'(e_exc_bundle));
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    idle();
    check("lit_reset_free", free, 64'd16);
    check("lit_reset_ret_count", ret_count, 64'd0);
    check("lit_reset_exc_valid", exc_valid, 64'd0);

    // Fill with four groups of four; a fifth request is refused.
    for (int g = 0; g < 4; g++) begin
      idle(); disp(4); cycle();
    end
    idle();
    check("lit_full_free", free, 64'd0);
    disp(1);
    #1;
    check("lit_full_reject", ins_accept, 64'd0);
    cycle();
    idle();
    check("lit_full_head_kept", ins_tag, 64'd0);

    // Out-of-order completion of tags 3,1,0,2 -> four retire together.
    cmpl(0, 3, 1'b0); cmpl(1, 1, 1'b0); cmpl(2, 0, 1'b0); cmpl(3, 2, 1'b0);
    cycle();
    idle(); cycle();
    check("lit_ret4_count", ret_count, 64'd4);
    check("lit_ret4_p", ret_p, 64'hC2040);     // old pregs 0,1,2,3
    check("lit_ret4_free", free, 64'd4);

    // Hole in the window: 4,5,7 complete, 6 late.
    idle(); cmpl(0, 4, 1'b0); cmpl(1, 5, 1'b0); cmpl(2, 7, 1'b0); cycle();
    idle(); cycle();
    check("lit_hole_count", ret_count, 64'd2);
    check("lit_hole_p", ret_p, 64'h144);       // old pregs 4,5
    idle(); cmpl(0, 6, 1'b0); cycle();
    check("lit_hole_wait", ret_count, 64'd0);
    idle(); cycle();
    check("lit_fill_count", ret_count, 64'd2);
    check("lit_fill_p", ret_p, 64'h1C6);       // old pregs 6,7

    // Drain 8..15 while refilling tags 0..3 (seq 17..20), then tag 0 excepts.
    idle(); for (int p = 0; p < 6; p++) cmpl(p, 8 + p, 1'b0); cycle();
    idle(); cmpl(0, 14, 1'b0); cmpl(1, 15, 1'b0); disp(4); cycle();
    idle(); cycle();
    idle(); cycle();
    idle(); cmpl(0, 0, 1'b1); cycle();
    idle(); disp(2);
    #1;
    check("lit_exc_reject", ins_accept, 64'd0);
    cycle();
    idle();
    check("lit_exc_valid", exc_valid, 64'd1);
    check("lit_exc_tag", exc_tag, 64'd0);
    check("lit_exc_bundle", exc_bundle, 64'(BASE + 57'd17));
    check("lit_exc_free", free, 64'd16);
    cycle();
    check("lit_exc_pulse", exc_valid, 64'd0);

    // Streaming traffic carries the pointers around several times.
    for (int c = 0; c < 20; c++) begin
      idle();
      if (LEN - q_tags.size() >= 4) disp(4);
      cmpl_oldest(4);
      cycle();
    end
    for (int c = 0; c < 12; c++) begin
      idle(); cmpl_oldest(CMPL); cycle();
    end
    // Step single instructions through until the oldest index is 13.
    for (int i = 0; i < 80 && !(q_tags.size() == 0 && m_tail == 13); i++) begin
      idle();
      if (q_tags.size() == 0) disp(1);
      else if (!m_rdy[q_tags[0]]) cmpl(0, q_tags[0], 1'b0);
      cycle();
    end
    idle();
    check("lit_align_tag", ins_tag, 64'd13);
    disp(4); cycle();
    idle(); disp(4); cycle();
    idle(); disp(2); cycle();
    idle();
    check("lit_wrap_free10", free, 64'd6);
    flush_en = 1'b1; flush_tag = 4'd15; disp(1);
    #1;
    check("lit_flush_reject", ins_accept, 64'd0);
    cycle();
    idle();
    check("lit_flush_free", free, 64'd13);
    cmpl(0, 15, 1'b0); cmpl(1, 14, 1'b0); cmpl(2, 13, 1'b0); cycle();
    idle(); cycle();
    check("lit_flush_ret", ret_count, 64'd3);
    idle(); disp(4); cycle();
    idle(); cmpl(0, 3, 1'b0); cmpl(1, 2, 1'b0); cmpl(2, 1, 1'b0); cmpl(3, 0, 1'b0); cycle();
    idle(); cycle();
    check("lit_wrap_ret", ret_count, 64'd4);

    // Reset while full and partially complete.
    for (int c = 0; c < 6; c++) begin
      idle(); cmpl_oldest(CMPL); cycle();
    end
    for (int g = 0; g < 4; g++) begin
      idle(); disp(4); cycle();
    end
    idle(); cmpl(0, q_tags[2], 1'b0); cmpl(1, q_tags[5], 1'b0); cycle();
    idle(); rst = 1'b1; cycle();
    idle();
    check("lit_rst_free", free, 64'd16);
    check("lit_rst_tag", ins_tag, 64'd0);
    check("lit_rst_ret_count", ret_count, 64'd0);
    check("lit_rst_ret_p", ret_p, 64'd0);
    check("lit_rst_exc_valid", exc_valid, 64'd0);
    check("lit_rst_exc_tag", exc_tag, 64'd0);
    check("lit_rst_exc_bundle", exc_bundle, 64'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
